// File: rtl/mips_mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
// Optional feature macro: MIPS_CTRL_ADDI_EN adds the ADDIEX/ADDIWB states.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEMADR   = 4'd3,
    MEMREAD  = 4'd4,
    MEMWB    = 4'd5,
    MEMWRITE = 4'd6,
    EXECUTE  = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10
`ifdef MIPS_CTRL_ADDI_EN
    ,
    ADDIEX   = 4'd11,
    ADDIWB   = 4'd12
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_WD     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_OUT = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  // fetch marks the state whose IRWrite/PCWrite are qualified by mem_ready
  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       fetch;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctl;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
  } ctrl_t;

  function automatic ctrl_t ctrl_decode(input state_t s, input logic [2:0] rtype_ctl);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.fetch     = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_ctl   = ALU_ADD;
        c.pc_src    = PCSRC_ALU;
      end
      DECODE: begin
        c.alu_src_b = SRCB_IMM_SH;
        c.alu_ctl   = ALU_ADD;
      end
      MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_ctl   = ALU_ADD;
      end
      MEMREAD: c.iord = 1'b1;
      MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      MEMWRITE: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_WD;
        c.alu_ctl   = rtype_ctl;
      end
      ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_WD;
        c.alu_ctl   = ALU_SUB;
        c.pc_src    = PCSRC_OUT;
        c.branch    = 1'b1;
      end
      JUMP: begin
        c.pc_src   = PCSRC_JMP;
        c.pc_write = 1'b1;
      end
`ifdef MIPS_CTRL_ADDI_EN
      ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_ctl   = ALU_ADD;
      end
      ADDIWB: c.reg_write = 1'b1;
`endif
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Controller <-> datapath bundle: decoded instruction fields in, strobes and selects out.
interface mips_mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero_i;
  logic       mem_ready;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic       illegal_o;
  logic [3:0] state_o;

  modport master (
    input  opcode, funct, zero_i, mem_ready,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, illegal_o, state_o
  );

  modport slave (
    output opcode, funct, zero_i, mem_ready,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, illegal_o, state_o
  );
endinterface

// File: rtl/mips_mc_ctrl_alu_dec.sv
// R-type funct decoder: ALU operation plus a flag for unsupported funct codes.
module mips_alu_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_ctl,
  output logic       funct_illegal
);

  always_comb begin
    alu_ctl       = ALU_ADD;
    funct_illegal = 1'b0;
    case (funct)
      FN_ADD:  alu_ctl = ALU_ADD;
      FN_SUB:  alu_ctl = ALU_SUB;
      FN_AND:  alu_ctl = ALU_AND;
      FN_OR:   alu_ctl = ALU_OR;
      FN_SLT:  alu_ctl = ALU_SLT;
      default: funct_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS main controller (Moore FSM, registered control outputs).
// Optional feature macro: MIPS_CTRL_ADDI_EN enables the addi execute/write-back path.
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input logic            clk_i_top,
  input logic            rst_i_top,
  mips_mc_ctrl_if.master bus
);

  state_t     state;
  state_t     state_nxt;
  ctrl_t      ctrl;
  logic       illegal;
  logic       set_illegal;
  logic [2:0] rtype_ctl;
  logic       funct_illegal;

  mips_alu_dec u_alu_dec (
    .funct         (bus.funct),
    .alu_ctl       (rtype_ctl),
    .funct_illegal (funct_illegal)
  );

  always_comb begin
    state_nxt   = state;
    set_illegal = 1'b0;
    case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: if (bus.mem_ready) state_nxt = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYPE:     state_nxt = EXECUTE;
          OP_BEQ:       state_nxt = BRANCH;
          OP_J:         state_nxt = JUMP;
`ifdef MIPS_CTRL_ADDI_EN
          OP_ADDI:      state_nxt = ADDIEX;
`endif
          default: begin
            state_nxt   = FETCH;
            set_illegal = 1'b1;
          end
        endcase
      end
      MEMADR:   state_nxt = (bus.opcode == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (bus.mem_ready) state_nxt = MEMWB;
      MEMWB:    state_nxt = FETCH;
      MEMWRITE: if (bus.mem_ready) state_nxt = FETCH;
      // An unsupported funct still computes an add but skips write-back
      EXECUTE: begin
        if (funct_illegal) begin
          state_nxt   = FETCH;
          set_illegal = 1'b1;
        end else begin
          state_nxt = ALUWB;
        end
      end
      ALUWB:    state_nxt = FETCH;
      BRANCH:   state_nxt = FETCH;
      JUMP:     state_nxt = FETCH;
`ifdef MIPS_CTRL_ADDI_EN
      ADDIEX:   state_nxt = ADDIWB;
      ADDIWB:   state_nxt = FETCH;
`endif
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register
  always_ff @(posedge clk_i_top) begin
    if (rst_i_top) begin
      state   <= IDLE;
      ctrl    <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      ctrl  <= ctrl_decode(state_nxt, rtype_ctl);
      if (set_illegal && ILLEGAL_TRAP) illegal <= 1'b1;
    end
  end

  assign bus.IorD       = ctrl.iord;
  assign bus.MemWrite   = ctrl.mem_write;
  assign bus.RegDst     = ctrl.reg_dst;
  assign bus.MemtoReg   = ctrl.mem_to_reg;
  assign bus.RegWrite   = ctrl.reg_write;
  assign bus.ALUSrcA    = ctrl.alu_src_a;
  assign bus.ALUSrcB    = ctrl.alu_src_b;
  assign bus.ALUControl = ctrl.alu_ctl;
  assign bus.PCSrc      = ctrl.pc_src;
  assign bus.illegal_o  = illegal;
  assign bus.state_o    = state;

  // Fetch-side loads only commit on the cycle memory actually returns the word
  assign bus.IRWrite = ctrl.fetch & bus.mem_ready;
  assign bus.PCEn    = (ctrl.pc_write & (bus.mem_ready | ~ctrl.fetch))
                     | (ctrl.branch & bus.zero_i);

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Randomized self-checking bench for mips_mc_ctrl against a per-instruction phase model.
module tb_mips_mc_ctrl;
  import mips_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_mc_ctrl_if bus();

  mips_mc_ctrl #(.ILLEGAL_TRAP(1'b1)) dut (
    .clk_i_top (clk),
    .rst_i_top (rst),
    .bus       (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic exp_ill   = 1'b0;

  typedef struct packed {
    logic [3:0] st;
    logic       irw, pcen, rw, mw, iord, rdst, m2r;
    logic [2:0] alu;
    logic       srca;
    logic [1:0] srcb, pcsrc;
    logic       ill;
  } obs_t;

  typedef struct {
    state_t st;
    logic   mr;
  } step_t;

  function automatic step_t mk(input state_t s, input logic mr);
    step_t t;
    t.st = s;
    t.mr = mr;
    return t;
  endfunction

  // {legal, alu op} for an R-type funct
  function automatic logic [3:0] rtype_info(input logic [5:0] fn);
    case (fn)
      6'b100000: return {1'b1, 3'b010};
      6'b100010: return {1'b1, 3'b110};
      6'b100100: return {1'b1, 3'b000};
      6'b100101: return {1'b1, 3'b001};
      6'b101010: return {1'b1, 3'b111};
      default:   return {1'b0, 3'b010};
    endcase
  endfunction

  function automatic obs_t expect_of(input state_t s, input logic mr, input logic z,
                                     input logic [2:0] rctl, input logic ill);
    obs_t e;
    e     = '0;
    e.st  = s;
    e.ill = ill;
    case (s)
      FETCH:    begin e.irw = mr; e.pcen = mr; e.alu = 3'b010; e.srcb = 2'b01; end
      DECODE:   begin e.alu = 3'b010; e.srcb = 2'b11; end
      MEMADR:   begin e.srca = 1'b1; e.srcb = 2'b10; e.alu = 3'b010; end
      MEMREAD:  e.iord = 1'b1;
      MEMWB:    begin e.rw = 1'b1; e.m2r = 1'b1; end
      MEMWRITE: begin e.iord = 1'b1; e.mw = 1'b1; end
      EXECUTE:  begin e.srca = 1'b1; e.alu = rctl; end
      ALUWB:    begin e.rw = 1'b1; e.rdst = 1'b1; end
      BRANCH:   begin e.srca = 1'b1; e.alu = 3'b110; e.pcsrc = 2'b01; e.pcen = z; end
      JUMP:     begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
`ifdef MIPS_CTRL_ADDI_EN
      ADDIEX:   begin e.srca = 1'b1; e.srcb = 2'b10; e.alu = 3'b010; end
      ADDIWB:   e.rw = 1'b1;
`endif
      default: ;
    endcase
    return e;
  endfunction

  function automatic obs_t observe();
    obs_t a;
    a.st    = bus.state_o;
    a.irw   = bus.IRWrite;
    a.pcen  = bus.PCEn;
    a.rw    = bus.RegWrite;
    a.mw    = bus.MemWrite;
    a.iord  = bus.IorD;
    a.rdst  = bus.RegDst;
    a.m2r   = bus.MemtoReg;
    a.alu   = bus.ALUControl;
    a.srca  = bus.ALUSrcA;
    a.srcb  = bus.ALUSrcB;
    a.pcsrc = bus.PCSrc;
    a.ill   = bus.illegal_o;
    return a;
  endfunction

  // Runs one instruction starting in FETCH at posedge+1; rst_at>=0 aborts with reset at that step.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int fw, input int mw, input int rst_at);
    step_t q[$];
    logic [3:0] rt;
    logic goes_illegal;
    obs_t e, a;
    rt = rtype_info(fn);
    goes_illegal = 1'b0;
    for (int i = 0; i < fw; i++) q.push_back(mk(FETCH, 1'b0));
    q.push_back(mk(FETCH, 1'b1));
    q.push_back(mk(DECODE, 1'($urandom_range(0, 1))));
    case (op)
      6'b100011: begin
        q.push_back(mk(MEMADR, 1'($urandom_range(0, 1))));
        for (int i = 0; i < mw; i++) q.push_back(mk(MEMREAD, 1'b0));
        q.push_back(mk(MEMREAD, 1'b1));
        q.push_back(mk(MEMWB, 1'($urandom_range(0, 1))));
      end
      6'b101011: begin
        q.push_back(mk(MEMADR, 1'($urandom_range(0, 1))));
        for (int i = 0; i < mw; i++) q.push_back(mk(MEMWRITE, 1'b0));
        q.push_back(mk(MEMWRITE, 1'b1));
      end
      6'b000000: begin
        q.push_back(mk(EXECUTE, 1'($urandom_range(0, 1))));
        if (rt[3]) q.push_back(mk(ALUWB, 1'($urandom_range(0, 1))));
        else       goes_illegal = 1'b1;
      end
      6'b000100: q.push_back(mk(BRANCH, 1'($urandom_range(0, 1))));
      6'b000010: q.push_back(mk(JUMP, 1'($urandom_range(0, 1))));
`ifdef MIPS_CTRL_ADDI_EN
      6'b001000: begin
        q.push_back(mk(ADDIEX, 1'($urandom_range(0, 1))));
        q.push_back(mk(ADDIWB, 1'($urandom_range(0, 1))));
      end
`endif
      default: goes_illegal = 1'b1;
    endcase
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero_i = z;
    for (int i = 0; i < q.size(); i++) begin
      bus.mem_ready = q[i].mr;
      #1;
      e = expect_of(q[i].st, q[i].mr, z, rt[2:0], exp_ill);
      a = observe();
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s step %0d: got %h expected %h", name, i, a, e);
      end
      if (i == rst_at) rst = 1'b1;
      @(posedge clk);
      #1;
      if (i == rst_at) begin
        exp_ill = 1'b0;
        rst = 1'b0;
        #1;
        e = expect_of(IDLE, 1'b0, z, 3'b0, 1'b0);
        a = observe();
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL %s reset-abort: got %h expected %h", name, a, e);
        end
        @(posedge clk);
        #1;
        return;
      end
      // the flag is raised on the edge that leaves DECODE/EXECUTE for FETCH
      if (goes_illegal && (i == q.size() - 1)) exp_ill = 1'b1;
    end
  endtask

  task automatic test_reset();
    obs_t e, a;
    rst = 1'b1;
    bus.opcode = 6'h3f; bus.funct = 6'h3f; bus.zero_i = 1'b1; bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      e = expect_of(IDLE, 1'b1, 1'b1, 3'b0, 1'b0);
      a = observe();
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL reset_hold cycle %0d: got %h expected %h", i, a, e);
      end
    end
    rst = 1'b0;
    #1;
    a = observe();
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL reset_idle: got %h expected %h", a, e);
    end
    @(posedge clk);
    #1;
    exp_ill = 1'b0;
  endtask

  task automatic test_rtype();
    run_instr("rtype_sub", 6'b000000, 6'b100010, 1'b0, 0, 0, -1);
    run_instr("rtype_slt", 6'b000000, 6'b101010, 1'b1, 0, 0, -1);
  endtask

  task automatic test_lw_wait();
    run_instr("lw_wait", 6'b100011, 6'h15, 1'b0, 2, 3, -1);
  endtask

  task automatic test_branch();
    run_instr("beq_taken", 6'b000100, 6'h00, 1'b1, 0, 0, -1);
    run_instr("beq_not_taken", 6'b000100, 6'h00, 1'b0, 0, 0, -1);
  endtask

  task automatic test_sw_jump();
    run_instr("sw_wait", 6'b101011, 6'h00, 1'b0, 1, 2, -1);
    run_instr("jump", 6'b000010, 6'h22, 1'b1, 0, 0, -1);
  endtask

  task automatic test_illegal();
    run_instr("bad_opcode", 6'b111111, 6'h00, 1'b0, 0, 0, -1);
    run_instr("after_bad_lw", 6'b100011, 6'h00, 1'b0, 0, 1, -1);
    run_instr("bad_funct", 6'b000000, 6'b111000, 1'b0, 0, 0, -1);
  endtask

  task automatic test_mid_reset();
    run_instr("lw_reset_in_memwb", 6'b100011, 6'h00, 1'b0, 0, 0, 4);
  endtask

  task automatic test_addi();
    run_instr("addi", 6'b001000, 6'h01, 1'b0, 0, 0, -1);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [7];
    logic [5:0] fns [6];
    logic [5:0] op, fn;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b000000};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    for (int n = 0; n < 40; n++) begin
      op = (n % 13 == 12) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      fn = (n % 9 == 8) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      run_instr("random", op, fn, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    obs_t e, a;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch();
    test_sw_jump();
    test_illegal();
    test_mid_reset();
    test_addi();
    test_back_to_back();
    bus.mem_ready = 1'b1;
    #1;
    e = expect_of(FETCH, 1'b1, bus.zero_i, 3'b0, exp_ill);
    a = observe();
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL final_fetch: got %h expected %h", a, e);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
